// File: rtl/c_mul_pkg.sv
// Shared encodings, field widths and the IEEE-754 single-precision classifier
// used by the multiplier result buffer.
package c_mul_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [1:0] C_CLS_NORM = 2'd0;
  localparam logic [1:0] C_CLS_ZERO = 2'd1;
  localparam logic [1:0] C_CLS_INF  = 2'd2;
  localparam logic [1:0] C_CLS_NAN  = 2'd3;

  typedef struct packed {
    logic [FP_W-1:0] result;
    logic            exc;
    logic [1:0]      cls;
  } entry_t;

  // Sign is ignored: -0 is a zero and -inf is an infinity; denormals count as normal.
  function automatic logic [1:0] classify(input logic [FP_W-1:0] value);
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    exp_f  = EXP_W'(value >> FRAC_W);
    frac_f = FRAC_W'(value);
    if (exp_f == '1)
      classify = (frac_f != '0) ? C_CLS_NAN : C_CLS_INF;
    else if (exp_f == '0 && frac_f == '0)
      classify = C_CLS_ZERO;
    else
      classify = C_CLS_NORM;
  endfunction

endpackage

// File: rtl/c_fp_classify.sv
// Combinational classifier for a 32-bit IEEE-754 single-precision value.
module c_fp_classify
  import c_mul_pkg::*;
(
  input  logic [FP_W-1:0] value,
  output logic [1:0]      cls
);

  assign cls = classify(value);

endmodule

// File: rtl/c_mul_rbuf.sv
// FIFO buffer for multiplier results, tagging each entry with its FP class and
// tracking a sticky exception flag. Define C_MUL_RBUF_EXC_CNT_EN for exc_count.
module c_mul_rbuf
  import c_mul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_exception,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_exception,
  output logic [1:0]               out_class,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_sticky,
  output logic                     sticky_exc
`ifdef C_MUL_RBUF_EXC_CNT_EN
  ,
  output logic [CNT_W-1:0]         exc_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("c_mul_rbuf: DEPTH must be a power of two in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("c_mul_rbuf: CNT_W must be at least 1");
  end

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   count;
  logic [1:0]         cls_p0;
  logic               push;
  logic               pop;

  // Push stage: classify the incoming product before it is written.
  c_fp_classify u_classify (
    .value (in_result),
    .cls   (cls_p0)
  );

  assign in_ready  = (count != LVL_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;

  // Storage is not reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{result: in_result, exc: in_exception, cls: cls_p0};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head stage: outputs read straight from registered storage.
  assign head          = mem[rd_ptr];
  assign out_result    = head.result;
  assign out_exception = head.exc;
  assign out_class     = head.cls;

  always_ff @(posedge clk) begin
    if (reset)
      sticky_exc <= 1'b0;
    else if (push && in_exception)
      sticky_exc <= 1'b1;
    else if (clr_sticky)
      sticky_exc <= 1'b0;
  end

`ifdef C_MUL_RBUF_EXC_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    sat_inc = (val == '1) ? val : val + CNT_W'(1);
  endfunction

  // A clear in the same cycle as an exception push restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset)
      exc_count <= '0;
    else if (push && in_exception)
      exc_count <= clr_sticky ? CNT_W'(1) : sat_inc(exc_count);
    else if (clr_sticky)
      exc_count <= '0;
  end
`endif

endmodule

// File: tb/tb_c_mul_rbuf.sv
// Bench for c_mul_rbuf: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_c_mul_rbuf;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = '0;
  logic             in_exception = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic             out_exception;
  logic [1:0]       out_class;
  logic [LVL_W-1:0] level;
  logic             clr_sticky = 1'b0;
  logic             sticky_exc;
`ifdef C_MUL_RBUF_EXC_CNT_EN
  logic [CNT_W-1:0] exc_count;
`endif

  c_mul_rbuf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_exception  (in_exception),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_exception (out_exception),
    .out_class     (out_class),
    .level         (level),
    .clr_sticky    (clr_sticky),
    .sticky_exc    (sticky_exc)
`ifdef C_MUL_RBUF_EXC_CNT_EN
    ,
    .exc_count     (exc_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a queue of accepted entries plus the flag/count.
  typedef struct packed {
    logic [31:0] r;
    logic        e;
  } ent_t;

  ent_t m_q[$];
  bit   m_sticky  = 0;
  int   m_cnt     = 0;
  bit   started   = 0;

  function automatic int ref_class(input logic [31:0] r);
    int unsigned e, f;
    e = (r / 32'h0080_0000) % 256;
    f = r % 32'h0080_0000;
    if (e == 255) return (f != 0) ? 3 : 2;
    if (e == 0 && f == 0) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit do_push, do_pop;
    if (reset) begin
      m_q.delete();
      m_sticky = 0;
      m_cnt    = 0;
    end else begin
      do_push = in_valid && (m_q.size() < DEPTH);
      do_pop  = out_ready && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back('{r: in_result, e: in_exception});
      if (do_push && in_exception) begin
        m_sticky = 1;
        m_cnt = clr_sticky ? 1 : ((m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1);
      end else if (clr_sticky) begin
        m_sticky = 0;
        m_cnt    = 0;
      end
    end
    started = 1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("level", 32'(level), 32'(m_q.size()));
      chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("sticky_exc", 32'(sticky_exc), 32'(m_sticky));
`ifdef C_MUL_RBUF_EXC_CNT_EN
      chk("exc_count", 32'(exc_count), 32'(m_cnt));
`endif
      if (m_q.size() != 0) begin
        chk("out_result", out_result, m_q[0].r);
        chk("out_exception", 32'(out_exception), 32'(m_q[0].e));
        chk("out_class", 32'(out_class), 32'(ref_class(m_q[0].r)));
      end
    end
  end

  // Apply inputs for one cycle; returns 2 time units after the edge.
  task automatic cyc(input bit iv, input logic [31:0] d, input bit ex,
                     input bit ordy, input bit clr, input bit rst);
    in_valid     = iv;
    in_result    = d;
    in_exception = ex;
    out_ready    = ordy;
    clr_sticky   = clr;
    reset        = rst;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 8'hFF, 23'h0};
      3: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      4: return {1'b0, 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] vals [4];
    logic [1:0]  cls_exp [4];
    vals[0] = 32'h0000_0000; vals[1] = 32'h7F80_0000;
    vals[2] = 32'h7FC0_0000; vals[3] = 32'h3F80_0000;
    cls_exp[0] = 2'd1; cls_exp[1] = 2'd2; cls_exp[2] = 2'd3; cls_exp[3] = 2'd0;

    // Model sanity pins
    chk("model_cls_zero", 32'(ref_class(32'h8000_0000)), 32'd1);
    chk("model_cls_nan", 32'(ref_class(32'hFF80_0001)), 32'd3);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sticky", 32'(sticky_exc), 32'd0);

    // Single push of 3.0 then drain
    cyc(1, 32'h4040_0000, 0, 1, 0, 0);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_result", out_result, 32'h4040_0000);
    chk("p1_class", 32'(out_class), 32'd0);
    chk("p1_level", 32'(level), 32'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("p1_level_after", 32'(level), 32'd0);

    // Fill with special values, then one push ignored while full
    for (int i = 0; i < 4; i++) cyc(1, vals[i], 0, 0, 0, 0);
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc(1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk("ign_level", 32'(level), 32'd4);
    chk("ign_head", out_result, 32'h0000_0000);
    chk("ign_sticky", 32'(sticky_exc), 32'd0);
    chk("head_class0", 32'(out_class), 32'(cls_exp[0]));

    // Full with push and pop together: pop only, then push across the wrap
    cyc(1, 32'h1111_1111, 0, 1, 0, 0);
    chk("fullpop_level", 32'(level), 32'd3);
    cyc(1, 32'h2222_2222, 0, 0, 0, 0);
    chk("wrap_level", 32'(level), 32'd4);
    for (int i = 1; i < 4; i++) begin
      chk("order_result", out_result, vals[i]);
      chk("order_class", 32'(out_class), 32'(cls_exp[i]));
      cyc(0, 0, 0, 1, 0, 0);
    end
    chk("wrap_result", out_result, 32'h2222_2222);
    cyc(0, 0, 0, 1, 0, 0);
    chk("drained", 32'(out_valid), 32'd0);

    // Sticky set wins over a simultaneous clear
    cyc(1, 32'h3F80_0000, 1, 1, 1, 0);
    chk("sticky_set_clr", 32'(sticky_exc), 32'd1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("sticky_clr", 32'(sticky_exc), 32'd0);

`ifdef C_MUL_RBUF_EXC_CNT_EN
    for (int i = 0; i < 5; i++) cyc(1, 32'h4000_0000, 1, 1, 0, 0);
    chk("cnt_sat", 32'(exc_count), 32'd3);
    cyc(0, 0, 0, 1, 1, 0);
    chk("cnt_clr", 32'(exc_count), 32'd0);
    cyc(1, 32'h4000_0000, 1, 1, 1, 0);
    chk("cnt_inc_wins", 32'(exc_count), 32'd1);
    cyc(0, 0, 0, 1, 1, 0);
`endif

    // Reset mid-operation with three entries held
    for (int i = 0; i < 3; i++) cyc(1, 32'h4100_0000 + 32'(i), 1, 0, 0, 0);
    chk("pre_rst_level", 32'(level), 32'd3);
    cyc(1, 32'h4200_0000, 1, 1, 1, 1);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sticky", 32'(sticky_exc), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60, rand_fp(), $urandom_range(0, 9) == 0,
          $urandom_range(0, 99) < 50, $urandom_range(0, 19) == 0,
          $urandom_range(0, 249) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/c_mul_rbuf.md
C_MUL_RBUF -- requirements
Module: c_mul_rbuf

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_W, default 8, width of the exception counter.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  a multiplier result is presented this cycle.
REQ-006 in_ready  out  1  buffer can accept; SHALL equal (count != DEPTH).
REQ-007 in_result  in  32  IEEE-754 single-precision product (mul_r).
REQ-008 in_exception  in  1  multiplier exception flag (mul_exception).
REQ-009 out_valid  out  1  head entry available; SHALL equal (count != 0).
REQ-010 out_ready  in  1  consumer accepts head entry.
REQ-011 out_result  out  32  head entry result.
REQ-012 out_exception  out  1  head entry exception flag.
REQ-013 out_class  out  2  head entry class: 0 normal, 1 zero, 2 infinity, 3 NaN.
REQ-014 level  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 clr_sticky  in  1  clears sticky_exc.
REQ-016 sticky_exc  out  1  set once any accepted entry carried in_exception=1.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-019 Push and pop in the same cycle SHALL leave level unchanged; this is legal when full (pop frees the slot: in_ready stays 0 that cycle, so no push) and when empty (no pop, push only).
REQ-020 in_valid while full SHALL be ignored; data is not stored and no flag changes.
REQ-021 Class SHALL be computed at push from in_result: exp=0xFF, frac!=0 -> 3; exp=0xFF, frac=0 -> 2; exp=0, frac=0 -> 1; else 0; stored with the entry.
REQ-022 out_result/out_exception/out_class SHALL be driven from the head entry combinationally from registered storage; latency push-to-out_valid SHALL be 1 cycle.
REQ-023 Head outputs SHALL remain stable while out_valid && !out_ready.
REQ-024 sticky_exc SHALL set on a push with in_exception=1; clr_sticky SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-025 Order SHALL be strictly FIFO; no entry is dropped or duplicated.

Reset
REQ-026 On reset: pointers, level, sticky_exc SHALL be 0; out_valid=0, in_ready=1.
REQ-027 Reset mid-operation SHALL discard all entries; storage contents need not clear; out_result/out_exception/out_class are don't-care while out_valid=0.
REQ-028 Reset SHALL take priority over simultaneous push, pop, and clr_sticky.

Configuration
REQ-029 Macro C_MUL_RBUF_EXC_CNT_EN defined: output exc_count [CNT_W-1:0] SHALL count accepted pushes with in_exception=1, saturate at all-ones, reset to 0, clear with clr_sticky (increment wins over clear in the same cycle, yielding 1).
REQ-030 Macro undefined: exc_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package c_mul_pkg SHALL hold class encodings (C_CLS_NORM/ZERO/INF/NAN), field widths (exponent 8, fraction 23), and a classify function.
REQ-032 One sub-module c_fp_classify (32-bit in, 2-bit class out, combinational) SHALL be instantiated on the push path.

Verification
REQ-033 Reset, then push 0x40400000 (3.0) with out_ready=1 -> next cycle out_valid=1, out_result=0x40400000, out_class=0, level=1 then 0.
REQ-034 out_ready=0, push 4 entries 0x00000000, 0x7F800000, 0x7FC00000, 0x3F800000 -> level=4, in_ready=0, classes 1,2,3,0 in order; 5th push ignored.
REQ-035 Full, in_valid=1 and out_ready=1 same cycle -> pop only, level 4->3; next cycle push accepted, level=4, order preserved across pointer wrap.
REQ-036 Push with in_exception=1 and clr_sticky=1 same cycle -> sticky_exc=1; next cycle clr_sticky=1 alone -> sticky_exc=0.
REQ-037 With C_MUL_RBUF_EXC_CNT_EN, CNT_W=2: 5 exception pushes -> exc_count=3 (saturated); clr_sticky -> 0.
REQ-038 Reset asserted with level=3 -> next cycle level=0, out_valid=0, in_ready=1, sticky_exc=0.
